// File: rtl/fft_butterfly_pkg.sv
// Shared defaults for the radix-2 butterfly datapath: FFT length, Q-format split,
// derived widths and the Q-format unity constant.
package fft_butterfly_pkg;
  localparam int FFT_N   = 16;
  localparam int FFT_I   = 2;
  localparam int FFT_F   = 14;
  localparam int FFT_W   = FFT_I + FFT_F;
  localparam int FFT_AW  = $clog2(FFT_N / 2);
  localparam int FFT_ONE = 1 << FFT_F;
endpackage

// File: rtl/fft_cmul.sv
// Complex multiply W*B: registered 4-product stage then combinational combine/rescale.
// `BFLY_ROUND_EN selects round-half-up on the >>>F rescale; otherwise floor.
module fft_cmul
  import fft_butterfly_pkg::*;
#(
  parameter int W = FFT_W,
  parameter int F = FFT_F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic signed [W-1:0] i_b_re,
  input  logic signed [W-1:0] i_b_im,
  input  logic signed [W-1:0] i_w_re,
  input  logic signed [W-1:0] i_w_im,
  output logic signed [W:0]   o_wb_re,
  output logic signed [W:0]   o_wb_im
);
  logic signed [2*W-1:0] r_rr, r_ii, r_ri, r_ir;
  logic signed [2*W:0]   w_re_acc, w_im_acc;
  logic signed [2*W:0]   w_re_rnd, w_im_rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
      r_ii <= '0;
      r_ri <= '0;
      r_ir <= '0;
    end else if (i_en) begin
      r_rr <= i_b_re * i_w_re;
      r_ii <= i_b_im * i_w_im;
      r_ri <= i_b_re * i_w_im;
      r_ir <= i_b_im * i_w_re;
    end
  end

  // One guard bit so rr-ii and ri+ir cannot overflow before rescaling.
  assign w_re_acc = {r_rr[2*W-1], r_rr} - {r_ii[2*W-1], r_ii};
  assign w_im_acc = {r_ri[2*W-1], r_ri} + {r_ir[2*W-1], r_ir};

`ifdef BFLY_ROUND_EN
  localparam bit [2*W:0] C_RND = {{(2*W+1-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
  assign w_re_rnd = w_re_acc + $signed(C_RND);
  assign w_im_rnd = w_im_acc + $signed(C_RND);
`else
  assign w_re_rnd = w_re_acc;
  assign w_im_rnd = w_im_acc;
`endif

  assign o_wb_re = (W+1)'(w_re_rnd >>> F);
  assign o_wb_im = (W+1)'(w_im_rnd >>> F);
endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly X=(A+W*B)/2, Y=(A-W*B)/2; drives the twiddle ROM read port.
// Fixed 3-cycle latency, one item per cycle, no backpressure.
module fft_butterfly
  import fft_butterfly_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int I = FFT_I,
  parameter int F = FFT_F,
  localparam int W  = I + F,
  localparam int AW = $clog2(N / 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_a_re,
  input  logic signed [W-1:0] i_a_im,
  input  logic signed [W-1:0] i_b_re,
  input  logic signed [W-1:0] i_b_im,
  input  logic [AW-1:0]       i_tw_addr,
  output logic                o_rd_en,
  output logic [AW-1:0]       o_rd_addr,
  input  logic signed [W-1:0] i_rd_data_re,
  input  logic signed [W-1:0] i_rd_data_im,
  output logic                o_valid,
  output logic signed [W-1:0] o_x_re,
  output logic signed [W-1:0] o_x_im,
  output logic signed [W-1:0] o_y_re,
  output logic signed [W-1:0] o_y_im
);
  logic                r_v1, r_v2, r_valid;
  logic signed [W-1:0] r_a1_re, r_a1_im, r_b_re, r_b_im;
  logic signed [W-1:0] r_a2_re, r_a2_im;
  logic signed [W-1:0] r_x_re, r_x_im, r_y_re, r_y_im;
  logic signed [W:0]   w_wb_re, w_wb_im;
  logic signed [W+1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  // The ROM has one cycle of latency, so its data lines up with the S0 registers.
  assign o_rd_en   = i_valid & ~rst;
  assign o_rd_addr = i_tw_addr;

  fft_cmul #(.W(W), .F(F)) u_cmul (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_v1),
    .i_b_re  (r_b_re),
    .i_b_im  (r_b_im),
    .i_w_re  (i_rd_data_re),
    .i_w_im  (i_rd_data_im),
    .o_wb_re (w_wb_re),
    .o_wb_im (w_wb_im)
  );

  assign w_sum_re = {{2{r_a2_re[W-1]}}, r_a2_re} + {w_wb_re[W], w_wb_re};
  assign w_sum_im = {{2{r_a2_im[W-1]}}, r_a2_im} + {w_wb_im[W], w_wb_im};
  assign w_dif_re = {{2{r_a2_re[W-1]}}, r_a2_re} - {w_wb_re[W], w_wb_re};
  assign w_dif_im = {{2{r_a2_im[W-1]}}, r_a2_im} - {w_wb_im[W], w_wb_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_valid <= 1'b0;
      r_a1_re <= '0;
      r_a1_im <= '0;
      r_b_re  <= '0;
      r_b_im  <= '0;
      r_a2_re <= '0;
      r_a2_im <= '0;
      r_x_re  <= '0;
      r_x_im  <= '0;
      r_y_re  <= '0;
      r_y_im  <= '0;
    end else begin
      r_v1    <= i_valid;
      r_v2    <= r_v1;
      r_valid <= r_v2;
      if (i_valid) begin
        r_a1_re <= i_a_re;
        r_a1_im <= i_a_im;
        r_b_re  <= i_b_re;
        r_b_im  <= i_b_im;
      end
      if (r_v1) begin
        r_a2_re <= r_a1_re;
        r_a2_im <= r_a1_im;
      end
      // Final halving is always floor; results wrap to W bits if callers exceed range.
      if (r_v2) begin
        r_x_re <= W'(w_sum_re >>> 1);
        r_x_im <= W'(w_sum_im >>> 1);
        r_y_re <= W'(w_dif_re >>> 1);
        r_y_im <= W'(w_dif_im >>> 1);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x_re  = r_x_re;
  assign o_x_im  = r_x_im;
  assign o_y_re  = r_y_re;
  assign o_y_im  = r_y_im;
endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: twiddle ROM model, arithmetic reference model with a
// due-cycle queue, per-cycle compare process and directed literal vectors.
module tb_fft_butterfly;
  localparam int W  = 16;
  localparam int AW = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_valid = 1'b0;
  logic signed [W-1:0] i_a_re = '0, i_a_im = '0, i_b_re = '0, i_b_im = '0;
  logic [AW-1:0]       i_tw_addr = '0;
  logic                o_rd_en;
  logic [AW-1:0]       o_rd_addr;
  logic signed [W-1:0] rd_re = '0, rd_im = '0;
  logic                o_valid;
  logic signed [W-1:0] o_x_re, o_x_im, o_y_re, o_y_im;

  fft_butterfly dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_a_re       (i_a_re),
    .i_a_im       (i_a_im),
    .i_b_re       (i_b_re),
    .i_b_im       (i_b_im),
    .i_tw_addr    (i_tw_addr),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data_re (rd_re),
    .i_rd_data_im (rd_im),
    .o_valid      (o_valid),
    .o_x_re       (o_x_re),
    .o_x_im       (o_x_im),
    .o_y_re       (o_y_re),
    .o_y_im       (o_y_im)
  );

  always #5 clk = ~clk;

  // cos(2*pi*k/16) and -sin(2*pi*k/16) in Q2.14
  int tw_re [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int tw_im [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

  always @(posedge clk) begin
    if (o_rd_en) begin
      rd_re <= W'(tw_re[o_rd_addr]);
      rd_im <= W'(tw_im[o_rd_addr]);
    end else begin
      rd_re <= '0;
      rd_im <= '0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint wrapn(longint v, int n);
    longint m;
    longint r;
    m = longint'(1) <<< n;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  typedef struct {
    int due;
    int xr, xi, yr, yi;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  bit   rst_seen = 1'b0;

  // Reference: complex arithmetic on plain integers, floor division by powers of two.
  task automatic model(int k, int ar, int ai, int br, int bi, output exp_t e);
    longint pr, pi, wbr, wbi;
    pr = longint'(br) * tw_re[k] - longint'(bi) * tw_im[k];
    pi = longint'(br) * tw_im[k] + longint'(bi) * tw_re[k];
`ifdef BFLY_ROUND_EN
    pr = pr + 8192;
    pi = pi + 8192;
`endif
    wbr = wrapn(pr >>> 14, W + 1);
    wbi = wrapn(pi >>> 14, W + 1);
    e.xr = int'(wrapn((ar + wbr) >>> 1, W));
    e.xi = int'(wrapn((ai + wbi) >>> 1, W));
    e.yr = int'(wrapn((ar - wbr) >>> 1, W));
    e.yi = int'(wrapn((ai - wbi) >>> 1, W));
    e.due = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else if (i_valid) begin
      model(int'(i_tw_addr), int'(i_a_re), int'(i_a_im), int'(i_b_re), int'(i_b_im), e);
      e.due = cyc + 3;
      q.push_back(e);
    end
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int lx_re = 0, lx_im = 0, ly_re = 0, ly_im = 0;
  int vcount   = 0;
  int run      = 0;
  int last_run = 0;

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (rst_seen) begin
      lx_re = 0; lx_im = 0; ly_re = 0; ly_im = 0;
    end
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    chk("rd_en", int'(o_rd_en), int'(i_valid & ~rst));
    if (i_valid && !rst) chk("rd_addr", int'(o_rd_addr), int'(i_tw_addr));
    chk("o_valid", int'(o_valid), int'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      lx_re = e.xr; lx_im = e.xi; ly_re = e.yr; ly_im = e.yi;
    end
    chk("x_re", int'(o_x_re), lx_re);
    chk("x_im", int'(o_x_im), lx_im);
    chk("y_re", int'(o_y_re), ly_re);
    chk("y_im", int'(o_y_im), ly_im);
    if (o_valid) begin
      vcount++;
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic drive(int k, int ar, int ai, int br, int bi);
    i_valid   = 1'b1;
    i_tw_addr = AW'(k);
    i_a_re = W'(ar); i_a_im = W'(ai);
    i_b_re = W'(br); i_b_im = W'(bi);
    @(posedge clk); #1;
  endtask

  task automatic apply(int k, int ar, int ai, int br, int bi);
    drive(k, ar, ai, br, bi);
    i_valid = 1'b0;
  endtask

  task automatic expect_lit(string nm, int xr, int xi, int yr, int yi);
    int n;
    n = 1;
    while (!o_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_x_re"}, int'(o_x_re), xr);
    chk({nm, "_x_im"}, int'(o_x_im), xi);
    chk({nm, "_y_re"}, int'(o_y_re), yr);
    chk({nm, "_y_im"}, int'(o_y_im), yi);
  endtask

  task automatic idle(int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_x_re", int'(o_x_re), 0);
    rst = 1'b0;
    idle(2);

    apply(0, 4096, 0, 2048, 0);
    expect_lit("k0", 3072, 0, 1024, 0);
    idle(5);
    chk("hold_x_re", int'(o_x_re), 3072);
    chk("hold_y_re", int'(o_y_re), 1024);

    apply(4, 0, 0, 4096, 0);
    expect_lit("k4", 0, -2048, 0, 2048);
    idle(3);

    apply(2, 1, 0, 1, 0);
`ifdef BFLY_ROUND_EN
    expect_lit("k2_round", 1, -1, 0, 0);
`else
    expect_lit("k2_floor", 0, -1, 0, 0);
`endif
    idle(3);

    v0 = vcount;
    for (int i = 0; i < 8; i++)
      drive(i, i * 1000 - 3000, 500 * i, 1500 * i - 5000, 7000 - 900 * i);
    idle(6);
    chk("burst_count", vcount - v0, 8);
    chk("burst_run", last_run, 8);

    apply(7, -26000, 26000, 26000, -26000);
    idle(4);
    apply(5, 20000, -13000, -18000, 24000);
    idle(4);

    drive(1, 1234, -4321, 10000, 5000);
    drive(3, -777, 888, -9000, 12000);
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_x_re", int'(o_x_re), 0);
    chk("rst_x_im", int'(o_x_im), 0);
    chk("rst_y_re", int'(o_y_re), 0);
    chk("rst_y_im", int'(o_y_im), 0);
    v0 = vcount;
    idle(6);
    chk("rst_no_valid", vcount - v0, 0);

    apply(6, 3000, -2000, 8000, 4000);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
